// File: rtl/seq_frame_tx_pkg.sv
// seq_pkg: sync marker constants, FSM state type and counter sizing helper for seq_frame_tx
package seq_pkg;
  localparam logic [3:0] SYNC_PATTERN = 4'b1010;
  localparam int SYNC_LEN = 4;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
  function automatic int cnt_width(int data_w, int gap_cycles);
    int m;
    m = data_w > gap_cycles ? data_w : gap_cycles;
    m = m > SYNC_LEN ? m : SYNC_LEN;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if: payload handshake plus serial output bundle of seq_frame_tx
interface seq_frame_tx_if #(parameter int DATA_W = 8);
  logic in_valid, in_ready, dout, dout_valid, busy, frame_done;
  logic [DATA_W-1:0] in_data;
  modport master(output in_valid, in_data, input in_ready, dout, dout_valid, busy, frame_done);
  modport slave(input in_valid, in_data, output in_ready, dout, dout_valid, busy, frame_done);
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serialises sync 1010 + payload MSB-first (+ even parity when SEQ_TX_PARITY_EN) + idle gap
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  seq_frame_tx_if.slave bus
);
  localparam int CW = cnt_width(DATA_W, GAP_CYCLES);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] sr, sr_n, rot;
  logic dout_n, dv_n, fd_n;
  // rotate rather than shift so the payload is whole again when parity is needed
  assign rot = (sr << 1) | (sr >> (DATA_W - 1));
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    dout_n = 1'b0;
    dv_n = 1'b0;
    fd_n = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        state_n = SYNC;
        cnt_n = '0;
        sr_n = bus.in_data;
        dout_n = SYNC_PATTERN[SYNC_LEN-1];
        dv_n = 1'b1;
      end
      SYNC: begin
        dv_n = 1'b1;
        if (cnt == SYNC_LAST) begin
          state_n = DATA;
          cnt_n = '0;
          dout_n = sr[DATA_W-1];
          sr_n = rot;
        end else begin
          cnt_n = cnt + 1'b1;
          dout_n = SYNC_PATTERN[2'(SYNC_LEN-2)-cnt[1:0]];
        end
      end
      DATA: if (cnt == DATA_LAST) begin
        cnt_n = '0;
`ifdef SEQ_TX_PARITY_EN
        state_n = PAR;
        dout_n = ^sr;
        dv_n = 1'b1;
`else
        state_n = GAP;
        fd_n = 1'b1;
`endif
      end else begin
        cnt_n = cnt + 1'b1;
        dout_n = sr[DATA_W-1];
        dv_n = 1'b1;
        sr_n = rot;
      end
`ifdef SEQ_TX_PARITY_EN
      PAR: begin
        state_n = GAP;
        cnt_n = '0;
        fd_n = 1'b1;
      end
`endif
      GAP: if (cnt == GAP_LAST) begin
        state_n = IDLE;
        cnt_n = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      bus.dout <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      bus.dout <= dout_n;
      bus.dout_valid <= dv_n;
      bus.frame_done <= fd_n;
    end
  end
endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 1..32.
REQ-002 Parameter GAP_CYCLES, default 2, idle low cycles after each frame; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  payload offered.
REQ-006 in_data  input  DATA_W  payload, MSB transmitted first.
REQ-007 in_ready  output  1  block can accept a payload this cycle.
REQ-008 dout  output  1  serial bit stream, registered.
REQ-009 dout_valid  output  1  dout carries a frame bit (sync, data or parity), registered.
REQ-010 busy  output  1  a frame is in progress (any state other than IDLE).
REQ-011 frame_done  output  1  one-cycle pulse when a frame's last bit has been sent.

Function
REQ-012 Frame format SHALL be: sync marker 1,0,1,0, then DATA_W payload bits MSB-first, then an optional parity bit (REQ-027), then GAP_CYCLES cycles with dout=0 and dout_valid=0.
REQ-013 The FSM SHALL have the states IDLE, SYNC, DATA, PAR and GAP.
REQ-014 in_ready SHALL equal (state==IDLE), combinationally.
REQ-015 A payload SHALL be accepted on a rising edge where in_valid && in_ready; in_data is latched into the shift register on that edge.
REQ-016 After acceptance in cycle T, the first sync bit SHALL appear on dout with dout_valid=1 in cycle T+1 (latency 1).
REQ-017 SYNC SHALL last 4 cycles, driving bits 1,0,1,0 in order, then enter DATA.
REQ-018 DATA SHALL last DATA_W cycles, emitting the latched payload MSB-first, then enter PAR if parity is compiled in, else GAP.
REQ-019 GAP SHALL last GAP_CYCLES cycles, then return to IDLE.
REQ-020 frame_done SHALL be 1 for exactly the first GAP cycle of each completed frame.
REQ-021 In IDLE and GAP, dout and dout_valid SHALL be 0.
REQ-022 in_data changes after acceptance SHALL NOT affect the frame in progress.
REQ-023 in_valid while in_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-024 If in_valid is held high, back-to-back frames SHALL start every 5+DATA_W+P+GAP_CYCLES cycles, where P=1 with parity and 0 without.
REQ-025 Bit and gap counters SHALL be sized to hold max(DATA_W, GAP_CYCLES) without wrap, and SHALL clear on every state change.

Reset
REQ-026 While rst=0: state=IDLE, shift register and counters cleared, dout=0, dout_valid=0, busy=0, frame_done=0, in_ready=1. Assertion mid-frame SHALL abort the frame immediately, with no frame_done. The first accept SHALL be possible on the first rising edge after release.

Configuration
REQ-027 Macro SEQ_TX_PARITY_EN defined: PAR state is present and emits one even-parity bit (XOR of the payload) with dout_valid=1. Macro undefined: PAR state, its logic and its cycle are absent, and DATA goes directly to GAP.

Structure
REQ-028 Package seq_pkg SHALL hold the constants SYNC_PATTERN=4'b1010 and SYNC_LEN=4, and the state enum typedef (IDLE, SYNC, DATA, PAR, GAP).
REQ-029 The block SHALL be a single module with no sub-module; the shift register, counters and FSM are all local.

Verification
REQ-030 No parity, DATA_W=8, GAP=2, in_data=8'hC5 accepted at T: dout over T+1..T+12 = 1,0,1,0,1,1,0,0,0,1,0,1 with dout_valid=1; frame_done=1 at T+13 only; in_ready=1 at T+15.
REQ-031 SEQ_TX_PARITY_EN defined: 8'hC5 produces parity bit 0 at T+13; 8'h01 produces parity bit 1; frame_done=1 at T+14.
REQ-032 in_valid held high, payloads 8'hA0 then 8'h0F, no parity, GAP=2: accepts occur at T and T+15; no dout_valid during T+13..T+14.
REQ-033 rst pulsed low during the third DATA bit: dout=0 and dout_valid=0 asynchronously; no frame_done; the next payload is sent as a complete, correct frame.
REQ-034 in_valid pulsed high with 8'hFF while busy: ignored, no extra frame; the current frame's bits are unchanged.
REQ-035 Changing in_data every cycle after acceptance of 8'h3C: transmitted payload bits remain 0,0,1,1,1,1,0,0.
